aes_ctx_scheduler: RTL

Time-shares one AES counter-mode block engine between NUM_CH message channels.
- Holds a per-channel context: 128-bit key, 128-bit sync/counter, valid flag.
- Arbitrates round-robin among channels with pending traffic.
- Serves the engine's key_and_sync_req / new_sync_req handshake: presents key and sync, advances the counter per block, writes the counter back at end of burst.
- Sits between the host configuration path and the AES block engine.

---
 rtl/aes_ctx_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/aes_ctx_scheduler.sv
// Shares one AES counter-mode engine among NUM_CH channels: per-channel key/sync
// contexts, round-robin burst grants and the engine's key/sync request handshake.
module aes_ctx_scheduler #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [127:0]              cfg_key,
  input  logic [127:0]              cfg_sync,
  output logic                      cfg_err,
  input  logic [NUM_CH-1:0]         ch_req,
  output logic [NUM_CH-1:0]         ch_gnt,
  input  logic                      key_and_sync_req,
  input  logic                      new_sync_req,
  output logic                      key_and_sync_vld,
  output logic [127:0]              key,
  output logic [127:0]              sync,
  output logic                      busy
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned CW    = IDX_W + 1;
  localparam int unsigned BC_W  = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_RUN, S_WB} state_t;

  state_t             r_state, w_next;
  logic [127:0]       r_ctx_key  [NUM_CH];
  logic [127:0]       r_ctx_sync [NUM_CH];
  logic [NUM_CH-1:0]  r_ctx_valid;
  logic [IDX_W-1:0]   r_idx, r_rr, w_pick;
  logic [BC_W-1:0]    r_blk_cnt;
  logic [NUM_CH-1:0]  r_gnt, w_cfg_mask, w_elig;
  logic [127:0]       r_key, r_sync, w_sync_inc;
  logic [CW-1:0]      w_cand;
  logic               r_vld, r_busy, r_cfg_err;
  logic               w_found, w_cfg_rej, w_cfg_ok, w_burst_end, w_vld_set;

  assign cfg_err          = r_cfg_err;
  assign ch_gnt           = r_gnt;
  assign key_and_sync_vld = r_vld;
  assign key              = r_key;
  assign sync             = r_sync;
  assign busy             = r_busy;

  // A channel being rewritten this cycle is not eligible for arbitration.
  always_comb begin
    w_cfg_mask = '0;
    if (cfg_wr) w_cfg_mask[cfg_ch] = 1'b1;
    w_elig      = ch_req & r_ctx_valid & ~w_cfg_mask;
    w_cfg_rej   = cfg_wr && (r_state == S_LOAD || r_state == S_RUN) && (cfg_ch == r_idx);
    w_cfg_ok    = cfg_wr && !w_cfg_rej;
    w_burst_end = ((r_blk_cnt + BC_W'(1)) == BC_W'(BURST_LEN)) || !ch_req[r_idx];
    w_sync_inc  = r_sync;
    w_sync_inc[CNT_W-1:0] = r_sync[CNT_W-1:0] + CNT_W'(1);
  end

  // Round-robin pick: first eligible channel at or above the rr pointer, wrapping.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_cand = {1'b0, r_rr} + CW'(i);
      if (w_cand >= CW'(NUM_CH)) w_cand = w_cand - CW'(NUM_CH);
      if (!w_found && w_elig[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_vld_set = 1'b0;
    case (r_state)
      S_IDLE: if (|w_elig) w_next = S_ARB;
      S_ARB:  w_next = w_found ? S_LOAD : S_IDLE;
      S_LOAD: begin
        if (key_and_sync_req) begin
          w_next    = S_RUN;
          w_vld_set = 1'b1;
        end
      end
      S_RUN: begin
        if (new_sync_req) begin
          if (w_burst_end) w_next = S_WB;
          else             w_vld_set = 1'b1;
        end
      end
      S_WB:    w_next = (|w_elig) ? S_ARB : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_rr      <= '0;
      r_blk_cnt <= '0;
      r_gnt     <= '0;
      r_key     <= '0;
      r_sync    <= '0;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_busy    <= (w_next != S_IDLE);
      r_cfg_err <= w_cfg_rej;
      r_vld     <= w_vld_set;
      case (r_state)
        S_ARB: begin
          if (w_found) begin
            r_idx     <= w_pick;
            r_key     <= r_ctx_key[w_pick];
            r_sync    <= r_ctx_sync[w_pick];
            r_gnt     <= NUM_CH'(1) << w_pick;
            r_rr      <= (w_pick == IDX_W'(NUM_CH - 1)) ? '0 : w_pick + IDX_W'(1);
            r_blk_cnt <= '0;
          end
        end
        S_RUN: begin
          if (new_sync_req) begin
            r_sync    <= w_sync_inc;
            r_blk_cnt <= r_blk_cnt + BC_W'(1);
          end
        end
        S_WB:    r_gnt <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ctx_valid <= '0;
    else if (w_cfg_ok) r_ctx_valid <= r_ctx_valid | w_cfg_mask;
  end

  // Host writes take priority over the end-of-burst counter write-back.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_cfg_ok && cfg_ch == IDX_W'(i)) begin
        r_ctx_key[i]  <= cfg_key;
        r_ctx_sync[i] <= cfg_sync;
      end else if (r_state == S_WB && r_idx == IDX_W'(i)) begin
        r_ctx_sync[i] <= r_sync;
      end
    end
  end

endmodule
